// File: rtl/alb_operand_stage.sv
// ============================================================================
// Module   : alb_operand_stage
// Purpose  : Operand-fetch stage ahead of the ALB: register file, Q register,
//            source-pair select and registered R/S/CI/ALB_MI issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alb_operand_stage #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [2:0]    src_sel,
    input  logic [DW-1:0] d_in,
    input  logic          ci_in,
    input  logic [1:0]    mi_in,
    output logic [DW-1:0] R,
    output logic [DW-1:0] S,
    output logic          CI,
    output logic [1:0]    ALB_MI,
    output logic          out_valid,
    input  logic          stall,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          q_en,
    output logic [DW-1:0] q_out
);

    localparam int c_DEPTH = 1 << AW;

    logic [DW-1:0] r_rf [c_DEPTH];
    logic [DW-1:0] r_q;

    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_q;
    logic [DW-1:0] w_r;
    logic [DW-1:0] w_s;
    logic          w_accept;

    // Same-edge write-back is forwarded so an issued operand is never stale.
    assign w_a = (wb_en && (wb_addr == a_addr)) ? wb_data : r_rf[a_addr];
    assign w_b = (wb_en && (wb_addr == b_addr)) ? wb_data : r_rf[b_addr];
    assign w_q = q_en ? wb_data : r_q;

    assign op_ready = !(out_valid && stall);
    assign w_accept = op_valid && op_ready;
    assign q_out    = r_q;

    always_comb begin
        w_r = '0;
        w_s = '0;
        case (src_sel)
            3'd0: begin w_r = w_a;  w_s = w_q; end
            3'd1: begin w_r = w_a;  w_s = w_b; end
            3'd2: begin w_r = '0;   w_s = w_q; end
            3'd3: begin w_r = '0;   w_s = w_b; end
            3'd4: begin w_r = '0;   w_s = w_a; end
            3'd5: begin w_r = d_in; w_s = w_a; end
            3'd6: begin w_r = d_in; w_s = w_q; end
            default: begin w_r = d_in; w_s = '0; end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_q <= '0;
        end else begin
            if (wb_en) begin
                r_rf[wb_addr] <= wb_data;
            end
            if (q_en) begin
                r_q <= wb_data;
            end
        end
    end

    // While stalled with a valid op the outputs are frozen as a snapshot.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            R         <= '0;
            S         <= '0;
            CI        <= 1'b0;
            ALB_MI    <= 2'b00;
            out_valid <= 1'b0;
        end else if (w_accept) begin
            R         <= w_r;
            S         <= w_s;
            CI        <= ci_in;
            ALB_MI    <= mi_in;
            out_valid <= 1'b1;
        end else if (!stall) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alb_operand_stage.sv
// ============================================================================
// Module   : tb_alb_operand_stage
// Purpose  : Self-checking bench for alb_operand_stage (vector table plus
//            scoreboard of issued operations).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alb_operand_stage;

    logic       clk = 1'b0;
    logic       resetb = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] a_addr = '0;
    logic [3:0] b_addr = '0;
    logic [2:0] src_sel = '0;
    logic [7:0] d_in = '0;
    logic       ci_in = 1'b0;
    logic [1:0] mi_in = '0;
    logic [7:0] R;
    logic [7:0] S;
    logic       CI;
    logic [1:0] ALB_MI;
    logic       out_valid;
    logic       stall = 1'b0;
    logic       wb_en = 1'b0;
    logic [3:0] wb_addr = '0;
    logic [7:0] wb_data = '0;
    logic       q_en = 1'b0;
    logic [7:0] q_out;

    alb_operand_stage #(.DW(8), .AW(4)) dut (
        .clk(clk), .resetb(resetb), .op_valid(op_valid), .op_ready(op_ready),
        .a_addr(a_addr), .b_addr(b_addr), .src_sel(src_sel), .d_in(d_in),
        .ci_in(ci_in), .mi_in(mi_in), .R(R), .S(S), .CI(CI), .ALB_MI(ALB_MI),
        .out_valid(out_valid), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .q_en(q_en), .q_out(q_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] s;
        logic       ci;
        logic [1:0] mi;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] r;
        logic [7:0] s;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_entry required=scoreboard_entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, ".valid"}, 32'(out_valid), 32'd1);
            chk({name, ".R"}, 32'(R), 32'(e.r));
            chk({name, ".S"}, 32'(S), 32'(e.s));
            chk({name, ".CI"}, 32'(CI), 32'(e.ci));
            chk({name, ".MI"}, 32'(ALB_MI), 32'(e.mi));
        end
    endtask

    task automatic op(input string name, input logic [2:0] sel, input logic [3:0] a,
                      input logic [3:0] b, input logic [7:0] d, input logic ci,
                      input logic [1:0] mi, input logic [7:0] er, input logic [7:0] es);
        op_valid = 1'b1;
        src_sel  = sel;
        a_addr   = a;
        b_addr   = b;
        d_in     = d;
        ci_in    = ci;
        mi_in    = mi;
        sb.push_back('{r: er, s: es, ci: ci, mi: mi});
        step();
        op_valid = 1'b0;
        pop_check(name);
    endtask

    task automatic wr(input logic rf, input logic q, input logic [3:0] addr, input logic [7:0] data);
        wb_en   = rf;
        q_en    = q;
        wb_addr = addr;
        wb_data = data;
        step();
        wb_en = 1'b0;
        q_en  = 1'b0;
    endtask

    vec_t       vecs[8];
    logic [8:0] alb_sum;

    initial begin
        vecs[0] = '{sel: 3'd0, r: 8'h11, s: 8'h33};
        vecs[1] = '{sel: 3'd1, r: 8'h11, s: 8'h22};
        vecs[2] = '{sel: 3'd2, r: 8'h00, s: 8'h33};
        vecs[3] = '{sel: 3'd3, r: 8'h00, s: 8'h22};
        vecs[4] = '{sel: 3'd4, r: 8'h00, s: 8'h11};
        vecs[5] = '{sel: 3'd5, r: 8'hDD, s: 8'h11};
        vecs[6] = '{sel: 3'd6, r: 8'hDD, s: 8'h33};
        vecs[7] = '{sel: 3'd7, r: 8'hDD, s: 8'h00};

        // Reset state
        #3 resetb = 1'b0;
        step();
        step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.R", 32'(R), 32'd0);
        chk("rst.S", 32'(S), 32'd0);
        chk("rst.CI", 32'(CI), 32'd0);
        chk("rst.MI", 32'(ALB_MI), 32'd0);
        chk("rst.Q", 32'(q_out), 32'd0);
        resetb = 1'b1;
        step();
        chk("rst.op_ready", 32'(op_ready), 32'd1);

        // Write-back then issue
        wr(1'b1, 1'b0, 4'd3, 8'h5A);
        wr(1'b0, 1'b1, 4'd0, 8'h0F);
        chk("wb.q_out", 32'(q_out), 32'h0F);
        op("wb_issue", 3'd0, 4'd3, 4'd0, 8'h00, 1'b1, 2'b10, 8'h5A, 8'h0F);

        // Source-decode sweep, back to back
        wr(1'b1, 1'b0, 4'd1, 8'h11);
        wr(1'b1, 1'b0, 4'd2, 8'h22);
        wr(1'b0, 1'b1, 4'd0, 8'h33);
        for (int i = 0; i < 8; i++) begin
            op($sformatf("sweep%0d", i), vecs[i].sel, 4'd1, 4'd2, 8'hDD,
               1'(i), 2'(i), vecs[i].r, vecs[i].s);
        end
        step();
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        // Read-after-write bypass on A, B and Q
        wr(1'b1, 1'b0, 4'd5, 8'h77);
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 8'hC3;
        op("bypass_ab", 3'd1, 4'd5, 4'd5, 8'h00, 1'b0, 2'b01, 8'hC3, 8'hC3);
        wb_en = 1'b0;
        op("bypass_persist", 3'd4, 4'd5, 4'd0, 8'h00, 1'b0, 2'b00, 8'h00, 8'hC3);
        q_en = 1'b1; wb_data = 8'h44;
        op("bypass_q", 3'd0, 4'd1, 4'd0, 8'h00, 1'b0, 2'b11, 8'h11, 8'h44);
        q_en = 1'b0;

        // Stall: X held as snapshot while its source register is rewritten
        wr(1'b1, 1'b0, 4'd6, 8'h01);
        op("stall_x", 3'd1, 4'd6, 4'd2, 8'h00, 1'b0, 2'b00, 8'h01, 8'h22);
        stall = 1'b1;
        op_valid = 1'b1; src_sel = 3'd0; a_addr = 4'd6; ci_in = 1'b1; mi_in = 2'b01;
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 8'h99;
        #1;
        chk("stall.op_ready", 32'(op_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.R", i), 32'(R), 32'h01);
            chk($sformatf("stall%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d.op_ready", i), 32'(op_ready), 32'd0);
        end
        stall = 1'b0;
        wb_en = 1'b0;
        sb.push_back('{r: 8'h99, s: 8'h44, ci: 1'b1, mi: 2'b01});
        #1;
        chk("release.op_ready", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        pop_check("stall_y");

        // Asynchronous reset between edges
        wr(1'b0, 1'b1, 4'd0, 8'hFF);
        op("pre_reset", 3'd6, 4'd0, 4'd0, 8'h12, 1'b0, 2'b00, 8'h12, 8'hFF);
        #2 resetb = 1'b0;
        #1;
        chk("arst.R", 32'(R), 32'd0);
        chk("arst.S", 32'(S), 32'd0);
        chk("arst.Q", 32'(q_out), 32'd0);
        chk("arst.valid", 32'(out_valid), 32'd0);
        #2 resetb = 1'b1;
        step();
        op("arst_rf36", 3'd1, 4'd3, 4'd6, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
        op("arst_rf5", 3'd4, 4'd5, 4'd0, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
        op("arst_q", 3'd0, 4'd1, 4'd0, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);

        // End-to-end: add with carry in the ALB, result written to reg 0
        wr(1'b1, 1'b0, 4'd0, 8'h55);
        wr(1'b0, 1'b1, 4'd0, 8'h0F);
        op("e2e_issue", 3'd6, 4'd0, 4'd0, 8'hF0, 1'b1, 2'b10, 8'hF0, 8'h0F);
        alb_sum = {1'b0, R} + {1'b0, S} + 9'(CI);
        chk("e2e.CO", 32'(alb_sum[8]), 32'd1);
        wr(1'b1, 1'b0, 4'd0, alb_sum[7:0]);
        op("e2e_readback", 3'd4, 4'd0, 4'd0, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
